// File: rtl/regfile32_width32_pkg.sv
// Shared types and constants for the 32 x 32-bit MIPS register file.
// Optional same-cycle WB->ID bypass is enabled by REGFILE_WRITE_FORWARD_EN.
package regfile32_width32_pkg;
   localparam int WIDTH = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 1 << AW;

   typedef logic [WIDTH-1:0] word_t;
   typedef logic [AW-1:0]    addr_t;

   localparam addr_t REG_ZERO = 5'd0;
   localparam addr_t REG_SP   = 5'd29;
   localparam addr_t REG_RA   = 5'd31;
endpackage

// File: rtl/regfile32_width32_if.sv
// Write/read bus between the WB/ID stages and the register file.
// master drives addresses and write data; slave returns read data and trace.
interface regfile32_width32_if;
   import regfile32_width32_pkg::*;

   logic             we;
   addr_t            waddr;
   word_t            wdata;
   addr_t            raddr1;
   addr_t            raddr2;
   word_t            rdata1;
   word_t            rdata2;
   logic [DEPTH-1:0] wen_onehot;

   modport master (
      output we, waddr, wdata, raddr1, raddr2,
      input  rdata1, rdata2, wen_onehot
   );

   modport slave (
      input  we, waddr, wdata, raddr1, raddr2,
      output rdata1, rdata2, wen_onehot
   );
endinterface

// File: rtl/regfile32_width32_sub.sv
// Write-side index decoder and read-side 32:1 word selector.
// Register 0 never receives a write enable from the decoder.
module decoder5to32
   import regfile32_width32_pkg::*;
(
   input  addr_t            idx,
   input  logic             en,
   output logic [DEPTH-1:0] onehot
);
   // one-hot enable, suppressed for the hardwired zero register
   always_comb begin
      onehot = '0;
      if (en && (idx != REG_ZERO)) onehot[idx] = 1'b1;
   end
endmodule

module mux32x32
   import regfile32_width32_pkg::*;
(
   input  word_t din [DEPTH],
   input  addr_t sel,
   output word_t dout
);
   // plain indexed select of one register word
   always_comb begin
      dout = din[sel];
   end
endmodule

// File: rtl/regfile32_width32.sv
// MIPS register file: 32 x 32-bit, one write port, two combinational reads.
// Define REGFILE_WRITE_FORWARD_EN to bypass same-cycle write data to readers.
module regfile32_width32
   import regfile32_width32_pkg::*;
(
   input logic                clk,
   input logic                rst,
   regfile32_width32_if.slave rf
);
   word_t            regs_q [DEPTH];
   word_t            regs_d [DEPTH];
   logic [DEPTH-1:0] dec;
   logic [DEPTH-1:0] wen_onehot_q;
   logic [DEPTH-1:0] wen_onehot_d;
   word_t            sel1;
   word_t            sel2;
   logic             fwd1;
   logic             fwd2;

   decoder5to32 u_dec (
      .idx    (rf.waddr),
      .en     (rf.we),
      .onehot (dec)
   );

   // next-state: load the decoded register, keep the rest, pin r0 to zero
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         regs_d[i] = dec[i] ? rf.wdata : regs_q[i];
      end
      regs_d[0]    = '0;
      wen_onehot_d = dec;
   end

   // register array and decode trace, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
         wen_onehot_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
         wen_onehot_q <= wen_onehot_d;
      end
   end

   mux32x32 u_rd1 (
      .din  (regs_q),
      .sel  (rf.raddr1),
      .dout (sel1)
   );

   mux32x32 u_rd2 (
      .din  (regs_q),
      .sel  (rf.raddr2),
      .dout (sel2)
   );

`ifdef REGFILE_WRITE_FORWARD_EN
   assign fwd1 = rf.we && (rf.waddr != REG_ZERO) && (rf.raddr1 == rf.waddr);
   assign fwd2 = rf.we && (rf.waddr != REG_ZERO) && (rf.raddr2 == rf.waddr);
`else
   assign fwd1 = 1'b0;
   assign fwd2 = 1'b0;
`endif

   // read outputs: zero while in reset, else bypass or stored word
   always_comb begin
      rf.rdata1 = rst ? '0 : (fwd1 ? rf.wdata : sel1);
      rf.rdata2 = rst ? '0 : (fwd2 ? rf.wdata : sel2);
   end

   assign rf.wen_onehot = wen_onehot_q;
endmodule

// File: tb/tb_regfile32_width32.sv
// Directed bench for regfile32_width32 with an array-based reference model.
// Honours REGFILE_WRITE_FORWARD_EN for the same-cycle read expectation.
module tb_regfile32_width32;
`ifdef REGFILE_WRITE_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   regfile32_width32_if bus ();

   regfile32_width32 dut (
      .clk (clk),
      .rst (rst),
      .rf  (bus)
   );

   always #10 clk = ~clk;

   logic [31:0] m_regs [32];
   logic [31:0] m_wen = '0;

   initial for (int i = 0; i < 32; i++) m_regs[i] = '0;

   // reference model: architectural register state and last-cycle decode
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) m_regs[i] = '0;
         m_wen = '0;
      end else begin
         m_wen = '0;
         if (bus.we && bus.waddr != 0) begin
            m_regs[bus.waddr] = bus.wdata;
            m_wen = 32'd1 << bus.waddr;
         end
      end
   end

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (rst) return '0;
      if (a == 0) return '0;
      if (FWD && bus.we && bus.waddr == a) return bus.wdata;
      return m_regs[a];
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // per-cycle comparison against the model
   always @(negedge clk) begin
      chk("cyc_rdata1", bus.rdata1, exp_rd(bus.raddr1));
      chk("cyc_rdata2", bus.rdata2, exp_rd(bus.raddr2));
      chk("cyc_wen", bus.wen_onehot, m_wen);
   end

   task automatic cyc(input logic w, input logic [4:0] wa,
                      input logic [31:0] wd,
                      input logic [4:0] r1, input logic [4:0] r2);
      @(posedge clk);
      #1;
      bus.we     = w;
      bus.waddr  = wa;
      bus.wdata  = wd;
      bus.raddr1 = r1;
      bus.raddr2 = r2;
   endtask

   initial begin
      bus.we = 0; bus.waddr = 0; bus.wdata = 0;
      bus.raddr1 = 0; bus.raddr2 = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #2;
      chk("rst_rd1", bus.rdata1, 32'h0);
      chk("rst_wen", bus.wen_onehot, 32'h0);

      cyc(1, 5, 32'hDEADBEEF, 0, 0);
      cyc(0, 0, 0, 5, 5);
      #2;
      chk("t2_rd1", bus.rdata1, 32'hDEADBEEF);
      chk("t2_rd2", bus.rdata2, 32'hDEADBEEF);
      chk("t2_wen", bus.wen_onehot, 32'h0000_0020);

      cyc(1, 0, 32'hFFFFFFFF, 0, 5);
      #2;
      chk("t3_rd0_same", bus.rdata1, 32'h0);
      cyc(0, 0, 0, 0, 5);
      #2;
      chk("t3_rd0", bus.rdata1, 32'h0);
      chk("t3_rd5", bus.rdata2, 32'hDEADBEEF);
      chk("t3_wen", bus.wen_onehot, 32'h0);

      cyc(1, 31, 32'h1, 0, 0);
      cyc(1, 31, 32'h2, 0, 31);
      #2;
      chk("t4_same", bus.rdata2, FWD ? 32'h2 : 32'h1);
      cyc(0, 0, 0, 0, 31);
      #2;
      chk("t4_next", bus.rdata2, 32'h2);

      for (int i = 1; i < 32; i++)
         cyc(1, 5'(i), 32'(i) * 32'h01010101, 5'(i - 1), 5'(i));
      for (int a = 0; a < 32; a++)
         for (int b = 0; b < 32; b++)
            cyc(0, 0, 0, 5'(a), 5'(b));
      cyc(0, 0, 0, 29, 31);
      #2;
      chk("t5_sp", bus.rdata1, 32'h1D1D1D1D);
      chk("t5_ra", bus.rdata2, 32'h1F1F1F1F);
      cyc(0, 0, 0, 7, 7);
      #2;
      chk("t5_eq1", bus.rdata1, 32'h07070707);
      chk("t5_eq2", bus.rdata2, 32'h07070707);

      cyc(1, 3, 32'hABC, 5, 31);
      cyc(0, 0, 0, 5, 31);
      #2;
      chk("t1_pre_rd1", bus.rdata1, 32'h05050505);
      chk("t1_pre_wen", bus.wen_onehot, 32'h0000_0008);
      #1 rst = 1'b1;
      #1;
      chk("t1_async_rd1", bus.rdata1, 32'h0);
      chk("t1_async_rd2", bus.rdata2, 32'h0);
      chk("t1_async_wen", bus.wen_onehot, 32'h0);
      for (int i = 0; i < 32; i++)
         cyc(0, 0, 0, 5'(i), 5'(31 - i));
      cyc(0, 0, 0, 5, 31);
      rst = 1'b0;
      #2;
      chk("t1_post_rd1", bus.rdata1, 32'h0);
      chk("t1_post_rd2", bus.rdata2, 32'h0);

      cyc(1, 7, 32'h77, 7, 0);
      cyc(1, 7, 32'h55, 7, 0);
      #5 rst = 1'b1;
      cyc(0, 0, 0, 7, 7);
      rst = 1'b0;
      #2;
      chk("t6_rd7", bus.rdata1, 32'h0);
      chk("t6_wen", bus.wen_onehot, 32'h0);
      cyc(1, 7, 32'h99, 0, 0);
      cyc(0, 0, 0, 7, 0);
      #2;
      chk("t6_first_wr", bus.rdata1, 32'h99);

      @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
